seg_capture: RTL and testbench
==============================

# seg_capture

Receive-side counterpart of the seven-segment drivers. It monitors a time-multiplexed seven-segment display bus (active-low digit enables plus an active-low segment pattern). Once a pattern has been stable for a set number of cycles, it decodes the pattern back to a hex nibble and holds the recovered value of every digit in registers. It serves as an on-chip display monitor and self-check block in front of the board's segment outputs.

## Interface
- DIGITS, 8, number of multiplexed digits (≥1).
- STABLE, 4, consecutive identical samples needed before commit (≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- an  in  DIGITS  digit enables, active-low; bit i low selects digit i.
- seg  in  8  segment pattern, active-low; bit7..bit1 = segments a..g, bit0 = dp.
- err_clr  in  1  clears err.
- value  out  4*DIGITS  recovered nibbles; digit i at value[4i+3:4i].
- valid  out  DIGITS  digit i holds a decoded hex value.
- blank  out  DIGITS  digit i last committed as blank.
- err  out  1  sticky error flag.
- upd  out  1  one-cycle strobe: a digit's stored content changed.
- upd_idx  out  $clog2(DIGITS) (min 1)  digit index for upd.

## Operation
- Sample register s holds {an, seg[7:1]}; dp (seg[0]) is ignored everywhere, including the stability compare.
- Stability counter cnt, 0..STABLE, updates every edge:
  - an not one-cold (none low or several low): cnt←0.
  - {an, seg[7:1]} ≠ s: cnt←1.
  - Otherwise: cnt←cnt+1, saturating at STABLE.
  - s←input on every edge.
- Commit when cnt==STABLE-1, the input equals s, and an is one-cold. This happens once per stable run. Idx = position of the low an bit.
- Decode of seg[7:1] (a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - 1111111 = blank.
- Commit actions:
  - Legal hex: value[idx]←nibble, valid[idx]←1, blank[idx]←0.
  - Blank: valid[idx]←0, blank[idx]←1; value[idx] is unchanged.
  - Any other pattern: err←1; digit state is unchanged.
- upd←1 and upd_idx←idx on a commit that changes the stored {value, valid, blank} of that digit. Otherwise upd←0.
- Several an bits low when a sample is taken: err←1, no commit.
- All an high: idle, no error.
- err_clr clears err. A same-edge error set wins over err_clr.

## Timing
- Reset values:
  - value=0, valid=0, blank=all ones, err=0, upd=0, upd_idx=0.
  - cnt=0, s=all ones.
- Latency: input constant and legal at edges t..t+STABLE-1. value/valid/blank/upd update at edge t+STABLE-1, i.e. visible STABLE-1 cycles after the first sampling edge.
- upd is high for exactly one cycle per changing commit. Re-committing identical content gives no upd.
- Holding the same pattern indefinitely causes no further commit. A new commit needs a change and then STABLE stable samples.
- A change at any sample before commit restarts the count at 1.
- Reset mid-run discards partial count; nothing commits from the aborted run.
- Outputs are registered only; no combinational path from inputs to outputs.

## Test plan
- Reset: assert rst 2 cycles → value=0, valid=0, blank=8'hFF, err=0, upd=0.
- Single digit commit:
  - Stimulus: an=8'b11111011, seg=8'b00100100 held 6 edges.
  - At 4th edge: value[11:8]=2, valid[2]=1, blank[2]=0.
  - upd high for exactly 1 cycle with upd_idx=2; no further upd.
  - Toggling seg[0] during the hold does not delay the commit.
- Glitch: hold digit 0 pattern "5" 3 edges, change to "6" → no commit. Then hold "6" 4 edges → value[3:0]=6 at 4th edge.
- Blank after value:
  - Digit 0 holds 5, then seg=8'hFF held 4 edges.
  - Result: valid[0]=0, blank[0]=1, value[3:0]=5, upd pulse.
- Errors:
  - seg=8'b11111100 (g only) held 4 edges → err=1, digit unchanged.
  - err_clr → err=0.
  - err_clr on the same edge as a new error → err=1.
  - an=8'b11111100 → err=1, no commit.
- Full scan:
  - Digits 0..7 each show value i for 4 cycles, rotating.
  - Result: value=32'h76543210, valid=8'hFF, exactly 8 upd pulses.
  - Rst asserted after 2 cycles of digit 3 → all outputs return to reset values, no commit.

Source files
------------

// File: rtl/seg_capture_if.sv
// Bus between a seven-segment display driver and the seg_capture monitor.
// The driver side (master) owns the multiplexed display bus and err_clr;
// the monitor side (slave) returns the recovered digit state.
interface seg_capture_if #(
    parameter int DIGITS = 8
) ();
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Display bus, active-low on both digit enables and segments
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic                err_clr;

    // Recovered display state
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   valid;
    logic [DIGITS-1:0]   blank;
    logic                err;
    logic                upd;
    logic [IDXW-1:0]     upd_idx;

    modport master (
        output an, seg, err_clr,
        input  value, valid, blank, err, upd, upd_idx
    );

    modport slave (
        input  an, seg, err_clr,
        output value, valid, blank, err, upd, upd_idx
    );
endinterface

// File: rtl/seg_capture.sv
// Seven-segment bus monitor: waits until {an, seg[7:1]} has been identical
// for STABLE consecutive samples, then decodes the segment pattern back to a
// hex nibble (or blank) and stores it for the selected digit. Malformed
// patterns and multiple simultaneous digit enables raise a sticky error.
module seg_capture #(
    parameter int DIGITS = 8,
    parameter int STABLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg_capture_if.slave bus
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNTW = $clog2(STABLE + 1);
    localparam int SW   = DIGITS + 7;

    typedef enum logic [1:0] {
        PAT_HEX,
        PAT_BLANK,
        PAT_BAD
    } pat_kind_e;

    typedef struct packed {
        pat_kind_e  kind;
        logic [3:0] nib;
    } pat_dec_t;

    // Segment pattern a..g (active-low) back to a nibble or a blank digit
    function automatic pat_dec_t decode(input logic [6:0] p);
        pat_dec_t d;
        d.kind = PAT_HEX;
        d.nib  = 4'h0;
        case (p)
            7'b0000001: d.nib = 4'h0;
            7'b1001111: d.nib = 4'h1;
            7'b0010010: d.nib = 4'h2;
            7'b0000110: d.nib = 4'h3;
            7'b1001100: d.nib = 4'h4;
            7'b0100100: d.nib = 4'h5;
            7'b0100000: d.nib = 4'h6;
            7'b0001111: d.nib = 4'h7;
            7'b0000000: d.nib = 4'h8;
            7'b0000100: d.nib = 4'h9;
            7'b0001000: d.nib = 4'hA;
            7'b1100000: d.nib = 4'hB;
            7'b0110001: d.nib = 4'hC;
            7'b1000010: d.nib = 4'hD;
            7'b0110000: d.nib = 4'hE;
            7'b0111000: d.nib = 4'hF;
            7'b1111111: d.kind = PAT_BLANK;
            default:    d.kind = PAT_BAD;
        endcase
        return d;
    endfunction

    // Sampler state
    logic [SW-1:0]       s_q, s_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    // Recovered display state
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                err_q, err_d;
    logic                upd_q, upd_d;
    logic [IDXW-1:0]     upd_idx_q, upd_idx_d;

    // Input classification
    logic [DIGITS-1:0]   an_low;
    logic                one_cold;
    logic                multi_low;
    logic [SW-1:0]       sample;
    logic                same;
    logic                commit;
    logic [IDXW-1:0]     idx;
    pat_dec_t            dec;

    // The decimal point never takes part in capture or stability
    logic                unused_dp;
    assign unused_dp = bus.seg[0];

    assign an_low    = ~bus.an;
    assign one_cold  = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    assign multi_low = (an_low != '0) && !one_cold;
    assign sample    = {bus.an, bus.seg[7:1]};
    assign same      = (sample == s_q);
    assign dec       = decode(bus.seg[7:1]);

    // Commit fires exactly once per run: cnt passes through STABLE-1 only once
    assign commit    = one_cold && same && (cnt_q == CNTW'(STABLE - 1));

    // Position of the single low digit enable
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_low[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    // Stability counter: restart on change, hold at zero on idle/illegal enables
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        s_d   = sample;
        cnt_d = cnt_q;
        if (!one_cold) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CNTW'(1);
        end else if (cnt_q != CNTW'(STABLE)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Commit action on the selected digit, update strobe and sticky error
    always_comb begin
        logic       err_set;
        logic [3:0] old_nib;

        value_d   = value_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        err_set   = multi_low;
        old_nib   = value_q[4*idx +: 4];

        if (commit) begin
            case (dec.kind)
                PAT_HEX: begin
                    value_d[4*idx +: 4] = dec.nib;
                    valid_d[idx]        = 1'b1;
                    blank_d[idx]        = 1'b0;
                    upd_d = !valid_q[idx] || blank_q[idx] || (old_nib != dec.nib);
                end
                PAT_BLANK: begin
                    valid_d[idx] = 1'b0;
                    blank_d[idx] = 1'b1;
                    upd_d = valid_q[idx] || !blank_q[idx];
                end
                default: begin
                    err_set = 1'b1;
                end
            endcase
        end

        if (upd_d) begin
            upd_idx_d = idx;
        end

        // A new error on this edge wins over a clear request
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values regardless of statement order.
        if (rst) begin
            s_q       <= '1;
            cnt_q     <= '0;
            // NOTE: the per-digit store is reset like any other register because its reset contents (zero, invalid, blank) are visible on the outputs.
            value_q   <= '0;
            valid_q   <= '0;
            blank_q   <= '1;
            err_q     <= 1'b0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.valid   = valid_q;
    assign bus.blank   = blank_q;
    assign bus.err     = err_q;
    assign bus.upd     = upd_q;
    assign bus.upd_idx = upd_idx_q;
endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture: directed scenarios plus a randomized run, all
// checked against a run-length based reference model of the display monitor.
module tb_seg_capture;
    localparam int DIGITS = 8;
    localparam int STABLE = 4;

    // Active-low a..g patterns for hex digits 0..F
    localparam logic [6:0] PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_capture_if #(.DIGITS(DIGITS)) bus ();

    seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  m_val   [DIGITS];
    logic        m_valid [DIGITS];
    logic        m_blank [DIGITS];
    logic        m_err;
    logic        m_upd;
    int          m_upd_idx;
    logic [14:0] m_prev;
    int          m_run;
    int          m_upd_count;
    int          upd_seen;

    function automatic logic [7:0] hex_seg(input int v, input logic dp);
        return {PAT[v], dp};
    endfunction

    function automatic logic [7:0] an_sel(input int d);
        return ~(8'b1 << d);
    endfunction

    function automatic logic [31:0] m_value_vec();
        logic [31:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = m_val[i];
        return v;
    endfunction

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v;
        for (int i = 0; i < DIGITS; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [7:0] m_blank_vec();
        logic [7:0] v;
        for (int i = 0; i < DIGITS; i++) v[i] = m_blank[i];
        return v;
    endfunction

    // Model: a digit is taken when its exact bus picture has been seen
    // STABLE times in a row with exactly one digit enabled.
    task automatic model_edge(input logic [7:0] a, input logic [7:0] sg,
                              input logic clr, input logic r);
        logic [14:0] smp;
        int          lows;
        int          idx;
        int          hit;
        logic        err_set;
        if (r) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_val[i] = 4'h0; m_valid[i] = 1'b0; m_blank[i] = 1'b1;
            end
            m_err = 1'b0; m_upd = 1'b0; m_upd_idx = 0;
            m_prev = '1; m_run = 0;
            return;
        end
        smp    = {a, sg[7:1]};
        m_run  = (smp == m_prev) ? m_run + 1 : 1;
        m_prev = smp;
        lows = 0;
        idx  = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!a[i]) begin
                lows++;
                idx = i;
            end
        end
        err_set = (lows > 1);
        m_upd   = 1'b0;
        if (lows == 1 && m_run == STABLE) begin
            hit = -1;
            for (int v = 0; v < 16; v++) if (PAT[v] == sg[7:1]) hit = v;
            if (hit >= 0) begin
                if (!m_valid[idx] || m_blank[idx] || m_val[idx] != hit[3:0]) m_upd = 1'b1;
                m_val[idx] = hit[3:0]; m_valid[idx] = 1'b1; m_blank[idx] = 1'b0;
            end else if (sg[7:1] == 7'h7F) begin
                if (m_valid[idx] || !m_blank[idx]) m_upd = 1'b1;
                m_valid[idx] = 1'b0; m_blank[idx] = 1'b1;
            end else begin
                err_set = 1'b1;
            end
            if (m_upd) m_upd_idx = idx;
        end
        if (err_set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (m_upd) m_upd_count++;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, sample #1 later
    task automatic step(input logic [7:0] a, input logic [7:0] sg,
                        input logic clr, input logic r);
        bus.an = a; bus.seg = sg; bus.err_clr = clr; rst = r;
        @(posedge clk);
        model_edge(a, sg, clr, r);
        #1;
        if (bus.upd === 1'b1) upd_seen++;
    endtask

    task automatic test_reset();
        step(8'hFF, 8'hFF, 1'b0, 1'b1);
        step(8'hFF, 8'hFF, 1'b0, 1'b1);
        checks++;
        if (bus.value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h want 00000000", bus.value); end
        checks++;
        if (bus.valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h want 00", bus.valid); end
        checks++;
        if (bus.blank !== 8'hFF) begin errors++; $display("FAIL reset_blank: got %h want ff", bus.blank); end
        checks++;
        if (bus.err !== 1'b0 || bus.upd !== 1'b0 || bus.upd_idx !== 3'd0) begin
            errors++; $display("FAIL reset_flags: got err=%b upd=%b idx=%0d want 0 0 0", bus.err, bus.upd, bus.upd_idx);
        end
    endtask

    task automatic test_single_digit();
        int pulses;
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        pulses = upd_seen;
        for (int e = 1; e <= 6; e++) begin
            // dp toggles every edge and must not disturb the count
            step(8'b11111011, {7'b0010010, e[0]}, 1'b0, 1'b0);
            if (e < 4) begin
                checks++;
                if (bus.valid[2] !== 1'b0) begin errors++; $display("FAIL single_early_commit: edge %0d valid[2]=%b want 0", e, bus.valid[2]); end
            end else if (e == 4) begin
                checks++;
                if (bus.value[11:8] !== 4'h2 || bus.valid[2] !== 1'b1 || bus.blank[2] !== 1'b0) begin
                    errors++; $display("FAIL single_commit: got nib=%h valid=%b blank=%b want 2 1 0", bus.value[11:8], bus.valid[2], bus.blank[2]);
                end
                checks++;
                if (bus.upd !== 1'b1 || bus.upd_idx !== 3'd2) begin
                    errors++; $display("FAIL single_upd: got upd=%b idx=%0d want 1 2", bus.upd, bus.upd_idx);
                end
            end else begin
                checks++;
                if (bus.upd !== 1'b0) begin errors++; $display("FAIL single_extra_upd: edge %0d upd=%b want 0", e, bus.upd); end
            end
        end
        checks++;
        if (upd_seen - pulses !== 1) begin errors++; $display("FAIL single_pulse_count: got %0d want 1", upd_seen - pulses); end
        // Same content committed again: no update strobe
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        pulses = upd_seen;
        for (int e = 0; e < 5; e++) step(8'b11111011, 8'b00100101, 1'b0, 1'b0);
        checks++;
        if (upd_seen - pulses !== 0 || bus.value[11:8] !== 4'h2) begin
            errors++; $display("FAIL recommit_same: got pulses=%0d nib=%h want 0 2", upd_seen - pulses, bus.value[11:8]);
        end
    endtask

    task automatic test_glitch();
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int e = 0; e < 3; e++) step(an_sel(0), hex_seg(5, 1'b1), 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            step(an_sel(0), hex_seg(6, 1'b1), 1'b0, 1'b0);
            if (e == 3) begin
                checks++;
                if (bus.valid[0] !== 1'b0) begin errors++; $display("FAIL glitch_no_commit: valid[0]=%b want 0", bus.valid[0]); end
            end
        end
        checks++;
        if (bus.value[3:0] !== 4'h6 || bus.valid[0] !== 1'b1) begin
            errors++; $display("FAIL glitch_commit: got nib=%h valid=%b want 6 1", bus.value[3:0], bus.valid[0]);
        end
    endtask

    task automatic test_blank();
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) step(an_sel(0), hex_seg(5, 1'b1), 1'b0, 1'b0);
        checks++;
        if (bus.value[3:0] !== 4'h5) begin errors++; $display("FAIL blank_pre: got nib=%h want 5", bus.value[3:0]); end
        for (int e = 0; e < 4; e++) step(an_sel(0), 8'hFF, 1'b0, 1'b0);
        checks++;
        if (bus.valid[0] !== 1'b0 || bus.blank[0] !== 1'b1 || bus.value[3:0] !== 4'h5) begin
            errors++; $display("FAIL blank_commit: got valid=%b blank=%b nib=%h want 0 1 5", bus.valid[0], bus.blank[0], bus.value[3:0]);
        end
        checks++;
        if (bus.upd !== 1'b1 || bus.upd_idx !== 3'd0) begin
            errors++; $display("FAIL blank_upd: got upd=%b idx=%0d want 1 0", bus.upd, bus.upd_idx);
        end
    endtask

    task automatic test_errors();
        step(8'hFF, 8'hFF, 1'b0, 1'b1);
        step(8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int e = 0; e < 4; e++) step(an_sel(1), 8'b11111100, 1'b0, 1'b0);
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL err_bad_pattern: got %b want 1", bus.err); end
        checks++;
        if (bus.valid[1] !== 1'b0 || bus.blank[1] !== 1'b1 || bus.value[7:4] !== 4'h0 || bus.upd !== 1'b0) begin
            errors++; $display("FAIL err_digit_kept: got valid=%b blank=%b nib=%h upd=%b want 0 1 0 0", bus.valid[1], bus.blank[1], bus.value[7:4], bus.upd);
        end
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        checks++;
        if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus.err); end
        for (int e = 1; e <= 4; e++) step(an_sel(2), 8'b11111100, (e == 4), 1'b0);
        checks++;
        if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", bus.err); end
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            step(8'b11111100, hex_seg(3, 1'b1), 1'b0, 1'b0);
            if (e == 1) begin
                checks++;
                if (bus.err !== 1'b1) begin errors++; $display("FAIL err_multi_low: got %b want 1", bus.err); end
            end
        end
        checks++;
        if (bus.valid !== 8'h00 || bus.upd !== 1'b0) begin
            errors++; $display("FAIL err_multi_no_commit: got valid=%h upd=%b want 00 0", bus.valid, bus.upd);
        end
    endtask

    task automatic test_full_scan();
        int pulses;
        step(8'hFF, 8'hFF, 1'b0, 1'b1);
        step(8'hFF, 8'hFF, 1'b0, 1'b1);
        pulses = upd_seen;
        for (int d = 0; d < DIGITS; d++)
            for (int e = 0; e < 4; e++) step(an_sel(d), hex_seg(d, 1'b1), 1'b0, 1'b0);
        checks++;
        if (bus.value !== 32'h76543210 || bus.valid !== 8'hFF || bus.blank !== 8'h00) begin
            errors++; $display("FAIL scan_result: got value=%h valid=%h blank=%h want 76543210 ff 00", bus.value, bus.valid, bus.blank);
        end
        checks++;
        if (upd_seen - pulses !== 8) begin errors++; $display("FAIL scan_pulses: got %0d want 8", upd_seen - pulses); end
        // Second pass: reset lands two cycles into digit 3
        for (int d = 0; d < 3; d++)
            for (int e = 0; e < 4; e++) step(an_sel(d), hex_seg(d, 1'b1), 1'b0, 1'b0);
        step(an_sel(3), hex_seg(3, 1'b1), 1'b0, 1'b0);
        step(an_sel(3), hex_seg(3, 1'b1), 1'b0, 1'b0);
        step(an_sel(3), hex_seg(3, 1'b1), 1'b0, 1'b1);
        checks++;
        if (bus.value !== 32'h0 || bus.valid !== 8'h00 || bus.blank !== 8'hFF || bus.err !== 1'b0 || bus.upd !== 1'b0 || bus.upd_idx !== 3'd0) begin
            errors++; $display("FAIL scan_mid_reset: got value=%h valid=%h blank=%h err=%b upd=%b idx=%0d", bus.value, bus.valid, bus.blank, bus.err, bus.upd, bus.upd_idx);
        end
        for (int e = 0; e < 3; e++) step(an_sel(3), hex_seg(3, 1'b1), 1'b0, 1'b0);
        checks++;
        if (bus.valid !== 8'h00) begin errors++; $display("FAIL scan_aborted_run: got valid=%h want 00", bus.valid); end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [6:0] p;
        int         len;
        int         sel;
        for (int burst = 0; burst < 500; burst++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) a = 8'hFF;
            else if (sel == 1) a = an_sel($urandom_range(0, 7)) & an_sel($urandom_range(0, 7));
            else a = an_sel($urandom_range(0, 7));
            sel = $urandom_range(0, 17);
            if (sel < 16) p = PAT[sel];
            else if (sel == 16) p = 7'h7F;
            else p = 7'($urandom);
            len = $urandom_range(1, 6);
            for (int e = 0; e < len; e++) begin
                step(a, {p, 1'($urandom)}, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
                checks++;
                if (bus.value !== m_value_vec() || bus.valid !== m_valid_vec() || bus.blank !== m_blank_vec() ||
                    bus.err !== m_err || bus.upd !== m_upd || bus.upd_idx !== m_upd_idx[2:0]) begin
                    errors++;
                    $display("FAIL random_edge: got value=%h valid=%h blank=%h err=%b upd=%b idx=%0d want %h %h %h %b %b %0d",
                             bus.value, bus.valid, bus.blank, bus.err, bus.upd, bus.upd_idx,
                             m_value_vec(), m_valid_vec(), m_blank_vec(), m_err, m_upd, m_upd_idx);
                end
            end
        end
        checks++;
        if (upd_seen !== m_upd_count) begin errors++; $display("FAIL upd_total: got %0d want %0d", upd_seen, m_upd_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.an = 8'hFF;
        bus.seg = 8'hFF;
        bus.err_clr = 1'b0;
        m_upd_count = 0;
        upd_seen = 0;
        model_edge(8'hFF, 8'hFF, 1'b0, 1'b1);
        test_reset();
        test_single_digit();
        test_glitch();
        test_blank();
        test_errors();
        test_full_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
